// File: rtl/aux_frame_buffer.sv
// -----------------------------------------------------------------------------
// aux_frame_buffer
//   Double-buffered auxiliary register bank feeding the frame generator's aux
//   read port. The CPU writes the shadow bank and then requests a commit. The
//   banks swap on the next vertical-sync assertion, so every frame sees one
//   consistent aux data set. After a swap, the new active bank is copied word by
//   word into the new shadow bank. Partial CPU updates therefore accumulate
//   across frames.
//
//   Optional feature macro: AUX_FRAME_BUFFER_READBACK_EN
//     When it is defined, the block gains a registered shadow-bank readback
//     port (cpu_raddress_in / cpu_rdata_out).
//
// Ports
//   clock_in           in   pixel clock
//   reset_in           in   synchronous, active-high reset
//   v_sync_in          in   vertical sync (polarity set by VSYNC_ACTIVE_LOW)
//   cpu_write_in       in   write request to the shadow bank
//   cpu_address_in     in   write address
//   cpu_data_in        in   write data
//   cpu_ready_out      out  1 while writes/commits are accepted (IDLE)
//   commit_in          in   request a swap at the next v_sync assertion
//   commit_pending_out out  1 while waiting for v_sync
//   frame_swap_out     out  one-cycle pulse after the edge on which the banks swap
//   aux_raddress_in    in   read address from the frame generator
//   aux_data_out       out  active[aux_raddress_in], combinational
//   cpu_raddress_in    in   (readback only) shadow read address
//   cpu_rdata_out      out  (readback only) registered shadow read data
// -----------------------------------------------------------------------------
module aux_frame_buffer #(
    parameter int DATA_WIDTH        = 16,
    parameter int AUX_ADDRESS_WIDTH = 5,
    parameter int VSYNC_ACTIVE_LOW  = 1
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         v_sync_in,
    input  logic                         cpu_write_in,
    input  logic [AUX_ADDRESS_WIDTH-1:0] cpu_address_in,
    input  logic [DATA_WIDTH-1:0]        cpu_data_in,
    output logic                         cpu_ready_out,
    input  logic                         commit_in,
    output logic                         commit_pending_out,
    output logic                         frame_swap_out,
`ifdef AUX_FRAME_BUFFER_READBACK_EN
    input  logic [AUX_ADDRESS_WIDTH-1:0] cpu_raddress_in,
    output logic [DATA_WIDTH-1:0]        cpu_rdata_out,
`endif
    input  logic [AUX_ADDRESS_WIDTH-1:0] aux_raddress_in,
    output logic [DATA_WIDTH-1:0]        aux_data_out
);

    localparam int DEPTH = 1 << AUX_ADDRESS_WIDTH;
    localparam logic [AUX_ADDRESS_WIDTH-1:0] LAST_IDX = AUX_ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [AUX_ADDRESS_WIDTH-1:0] ONE_IDX  = AUX_ADDRESS_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY    = 2'd2
    } state_t;

    // Two physical banks. r_bank_sel names the active bank; the other bank is the shadow.
    logic [DATA_WIDTH-1:0]        r_bank [0:1][0:DEPTH-1];
    logic                         r_bank_sel;
    state_t                       r_state;
    logic [AUX_ADDRESS_WIDTH-1:0] r_copy_idx;
    logic                         r_vs_prev;      // previous v_sync, stored as "asserted"
    logic                         r_cpu_ready;
    logic                         r_commit_pending;
    logic                         r_frame_swap;

    logic                         w_vs_asserted;
    logic                         w_vs_edge;
    logic                         w_shadow_sel;

    // Normalise v_sync polarity and detect its assertion edge.
    always_comb begin
        w_vs_asserted = 1'b0;
        if (VSYNC_ACTIVE_LOW != 0) begin
            w_vs_asserted = ~v_sync_in;
        end else begin
            w_vs_asserted = v_sync_in;
        end
        w_vs_edge    = w_vs_asserted & ~r_vs_prev;
        w_shadow_sel = ~r_bank_sel;
    end

    // Drive the outputs. The status flags come from registers; the aux read is combinational.
    assign aux_data_out       = r_bank[r_bank_sel][aux_raddress_in];
    assign cpu_ready_out      = r_cpu_ready;
    assign commit_pending_out = r_commit_pending;
    assign frame_swap_out     = r_frame_swap;

    // Commit FSM, bank storage, copy-back sequencing and registered status flags.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
            r_bank_sel       <= 1'b0;
            r_state          <= ST_IDLE;
            r_copy_idx       <= '0;
            r_vs_prev        <= 1'b0;
            r_cpu_ready      <= 1'b1;
            r_commit_pending <= 1'b0;
            r_frame_swap     <= 1'b0;
        end else begin
            r_vs_prev    <= w_vs_asserted;
            r_frame_swap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The write and the commit use separate storage, so a write and a
                    // commit on the same edge both take effect, and the word is included.
                    if (cpu_write_in && r_cpu_ready) begin
                        r_bank[w_shadow_sel][cpu_address_in] <= cpu_data_in;
                    end
                    if (commit_in) begin
                        r_state          <= ST_PENDING;
                        r_cpu_ready      <= 1'b0;
                        r_commit_pending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (w_vs_edge) begin
                        r_bank_sel       <= ~r_bank_sel;
                        r_frame_swap     <= 1'b1;
                        r_copy_idx       <= '0;
                        r_state          <= ST_COPY;
                        r_commit_pending <= 1'b0;
                    end
                end
                ST_COPY: begin
                    // The bank select has already toggled, so this copies the new active
                    // bank into the new shadow bank.
                    r_bank[w_shadow_sel][r_copy_idx] <= r_bank[r_bank_sel][r_copy_idx];
                    if (r_copy_idx == LAST_IDX) begin
                        r_state     <= ST_IDLE;
                        r_cpu_ready <= 1'b1;
                    end else begin
                        r_copy_idx <= r_copy_idx + ONE_IDX;
                    end
                end
                default: begin
                    r_state          <= ST_IDLE;
                    r_cpu_ready      <= 1'b1;
                    r_commit_pending <= 1'b0;
                end
            endcase
        end
    end

`ifdef AUX_FRAME_BUFFER_READBACK_EN
    logic [DATA_WIDTH-1:0] r_cpu_rdata;

    // Registered shadow readback. During COPY it may show the old or the new word.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_cpu_rdata <= '0;
        end else begin
            r_cpu_rdata <= r_bank[w_shadow_sel][cpu_raddress_in];
        end
    end

    assign cpu_rdata_out = r_cpu_rdata;
`endif

endmodule

// File: tb/tb_aux_frame_buffer.sv
module tb_aux_frame_buffer;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic        v_sync_in;
    logic        cpu_write_in;
    logic [4:0]  cpu_address_in;
    logic [15:0] cpu_data_in;
    logic        cpu_ready_out;
    logic        commit_in;
    logic        commit_pending_out;
    logic        frame_swap_out;
    logic [4:0]  aux_raddress_in;
    logic [15:0] aux_data_out;
`ifdef AUX_FRAME_BUFFER_READBACK_EN
    logic [4:0]  cpu_raddress_in;
    logic [15:0] cpu_rdata_out;
`endif

    aux_frame_buffer dut (
        .clock_in           (clock_in),
        .reset_in           (reset_in),
        .v_sync_in          (v_sync_in),
        .cpu_write_in       (cpu_write_in),
        .cpu_address_in     (cpu_address_in),
        .cpu_data_in        (cpu_data_in),
        .cpu_ready_out      (cpu_ready_out),
        .commit_in          (commit_in),
        .commit_pending_out (commit_pending_out),
        .frame_swap_out     (frame_swap_out),
`ifdef AUX_FRAME_BUFFER_READBACK_EN
        .cpu_raddress_in    (cpu_raddress_in),
        .cpu_rdata_out      (cpu_rdata_out),
`endif
        .aux_raddress_in    (aux_raddress_in),
        .aux_data_out       (aux_data_out)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb[$];          // expected aux read data
    logic [15:0] m_active [32];  // reference model of the active bank
    logic [15:0] m_shadow [32];  // reference model of the shadow bank
    rd_vec_t     vecs [5];

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic read_check(input logic [4:0] a, input string nm);
        logic [15:0] e;
        sb.push_back(m_active[a]);
        aux_raddress_in = a;
        #2;
        e = sb.pop_front();
        check(nm, {16'd0, aux_data_out}, {16'd0, e});
    endtask

    task automatic do_write(input logic [4:0] a, input logic [15:0] d, input bit accept);
        cpu_write_in   = 1'b1;
        cpu_address_in = a;
        cpu_data_in    = d;
        tick();
        cpu_write_in = 1'b0;
        if (accept) m_shadow[a] = d;
    endtask

    task automatic do_commit();
        commit_in = 1'b1;
        tick();
        commit_in = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cpu_ready_out && n < 200) begin
            tick();
            n++;
        end
        check("ready_timeout", {31'd0, cpu_ready_out}, 32'd1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_active[i] = 16'd0;
            m_shadow[i] = 16'd0;
        end
    endtask

    initial begin
        int n;
        int swaps;
        vecs[0] = '{5'd0, 16'h0003};
        vecs[1] = '{5'd2, 16'h000A};
        vecs[2] = '{5'd5, 16'h07FF};
        vecs[3] = '{5'd7, 16'h0000};
        vecs[4] = '{5'd1, 16'h0000};

        reset_in = 1'b1; v_sync_in = 1'b1; cpu_write_in = 1'b0; cpu_address_in = 5'd0;
        cpu_data_in = 16'd0; commit_in = 1'b0; aux_raddress_in = 5'd0;
`ifdef AUX_FRAME_BUFFER_READBACK_EN
        cpu_raddress_in = 5'd0;
`endif
        model_reset();
        tick(); tick();
        reset_in = 1'b0;
        tick();

        // 1: reset state
        check("rst_ready", {31'd0, cpu_ready_out}, 32'd1);
        check("rst_pending", {31'd0, commit_pending_out}, 32'd0);
        check("rst_swap", {31'd0, frame_swap_out}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            read_check(5'(i), "rst_sweep");
            tick();
        end

        // 2: write, commit, swap on the v_sync fall
        do_write(5'd0, 16'h0003, 1'b1);
        do_write(5'd2, 16'h000A, 1'b1);
        do_commit();
        check("t2_pending", {31'd0, commit_pending_out}, 32'd1);
        check("t2_ready_low", {31'd0, cpu_ready_out}, 32'd0);
        read_check(5'd2, "t2_before_swap");
        v_sync_in = 1'b0;
        tick();
        check("t2_swap_pulse", {31'd0, frame_swap_out}, 32'd1);
        check("t2_pending_clr", {31'd0, commit_pending_out}, 32'd0);
        check("t2_ready_at_swap", {31'd0, cpu_ready_out}, 32'd0);
        m_active = m_shadow;
        read_check(5'd2, "t2_after_swap");
        n = 1;
        tick();
        check("t2_swap_one_cycle", {31'd0, frame_swap_out}, 32'd0);
        while (!cpu_ready_out && n < 100) begin
            n++;
            tick();
        end
        check("t2_busy_cycles", n, 32'd32);
        v_sync_in = 1'b1;
        tick();

        // 3: writes during PENDING and COPY are dropped
        do_commit();
        do_write(5'd7, 16'h1234, 1'b0);
        v_sync_in = 1'b0;
        tick();
        m_active = m_shadow;
        do_write(5'd7, 16'h1234, 1'b0);
        wait_ready();
        v_sync_in = 1'b1;
        tick();
        read_check(5'd7, "t3_dropped");
        read_check(5'd2, "t3_kept");

        // 4: v_sync with no commit, then v_sync held after a commit
        tick();
        v_sync_in = 1'b0;
        tick();
        check("t4_no_swap", {31'd0, frame_swap_out}, 32'd0);
        tick();
        v_sync_in = 1'b1;
        tick();
        check("t4_no_pending", {31'd0, commit_pending_out}, 32'd0);
        read_check(5'd0, "t4_data_kept");
        do_commit();
        v_sync_in = 1'b0;
        swaps = 0;
        repeat (100) begin
            tick();
            if (frame_swap_out) swaps++;
        end
        check("t4_one_swap", swaps, 32'd1);
        m_active = m_shadow;
        v_sync_in = 1'b1;
        tick();

        // 5: partial updates accumulate
        do_write(5'd5, 16'h07FF, 1'b1);
        do_commit();
        v_sync_in = 1'b0;
        tick();
        m_active = m_shadow;
        wait_ready();
        v_sync_in = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t5_table_model", {16'd0, m_active[vecs[i].addr]}, {16'd0, vecs[i].exp});
            read_check(vecs[i].addr, "t5_table");
            tick();
        end
`ifdef AUX_FRAME_BUFFER_READBACK_EN
        cpu_raddress_in = 5'd5;
        tick();
        check("rb_shadow", {16'd0, cpu_rdata_out}, 32'h07FF);
`endif

        // 6: reset during COPY
        do_commit();
        v_sync_in = 1'b0;
        tick();
        repeat (10) tick();
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        model_reset();
        check("t6_ready", {31'd0, cpu_ready_out}, 32'd1);
        check("t6_pending", {31'd0, commit_pending_out}, 32'd0);
        check("t6_swap", {31'd0, frame_swap_out}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            read_check(5'(i), "t6_sweep");
            tick();
        end
        check("t6_idle_no_swap", {31'd0, frame_swap_out}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
